adder_operand_sequencer: RTL and testbench

ADDER_OPERAND_SEQUENCER -- requirements
Module: adder_operand_sequencer

---
 rtl/adder_operand_sequencer_if.sv | 41 ++++
 rtl/adder_operand_sequencer.sv | 115 +++++++++++
 tb/tb_adder_operand_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_operand_sequencer_if.sv
// adder_operand_sequencer_if
//   Bundles the operand byte stream, the adder connection and the result
//   outputs of adder_operand_sequencer.
//   slave  : the sequencer's view (byte stream and adder results in;
//            operands, READY and results out).
//   master : the environment's view (byte source plus the external adder).
//   OVERFLOW exists only when ADDER_SEQ_OVERFLOW_EN is defined.
interface adder_operand_sequencer_if;
  logic [7:0] DATA_IN;
  logic       DATA_VALID;
  logic       OP_SEL;
  logic [7:0] RESULT_IN;
  logic       CARRY_IN;
  logic       READY;
  logic [7:0] X;
  logic [7:0] Y;
  logic       SEL;
  logic [7:0] RESULT;
  logic       CARRY;
  logic       DONE;
  logic [7:0] OP_COUNT;
`ifdef ADDER_SEQ_OVERFLOW_EN
  logic       OVERFLOW;
`endif

  modport slave (
    input  DATA_IN, DATA_VALID, OP_SEL, RESULT_IN, CARRY_IN,
    output READY, X, Y, SEL, RESULT, CARRY, DONE, OP_COUNT
`ifdef ADDER_SEQ_OVERFLOW_EN
    , OVERFLOW
`endif
  );

  modport master (
    output DATA_IN, DATA_VALID, OP_SEL, RESULT_IN, CARRY_IN,
    input  READY, X, Y, SEL, RESULT, CARRY, DONE, OP_COUNT
`ifdef ADDER_SEQ_OVERFLOW_EN
    , OVERFLOW
`endif
  );
endinterface

// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer
//   Collects two operand bytes (X then Y) from a valid/ready byte stream,
//   presents them with the add/subtract select to an external 8-bit adder,
//   waits one settle cycle, then captures the adder's sum and carry and
//   pulses DONE. One operation every 3 cycles at full throughput.
// Ports:
//   CLK  - rising-edge clock
//   RST  - synchronous active-high reset
//   bus  - adder_operand_sequencer_if.slave:
//          DATA_IN/DATA_VALID/READY : operand byte handshake
//          OP_SEL                   : 0 add, 1 subtract (taken with X)
//          X/Y/SEL                  : operands to the adder
//          RESULT_IN/CARRY_IN       : adder sum and carry-out
//          RESULT/CARRY/DONE        : captured result, DONE one-cycle pulse
//          OP_COUNT                 : completed operations, mod 256
// Configuration:
//   ADDER_SEQ_OVERFLOW_EN - adds registered signed-overflow flag OVERFLOW.
module adder_operand_sequencer (
  input  logic                      CLK,
  input  logic                      RST,
  adder_operand_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD_X = 2'd0,
    LOAD_Y = 2'd1,
    EXEC   = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_ready;
  logic [7:0] r_x;
  logic [7:0] r_y;
  logic       r_sel;
  logic [7:0] r_result;
  logic       r_carry;
  logic       r_done;
  logic [7:0] r_op_count;
  logic       w_xfer;

  // READY is registered alongside the state, so it is low exactly in EXEC.
  assign w_xfer = bus.DATA_VALID && r_ready;

`ifdef ADDER_SEQ_OVERFLOW_EN
  logic       r_overflow;
  logic [7:0] w_ye;
  logic       w_overflow;

  // Effective second adder operand: subtraction feeds ~Y with carry-in 1.
  assign w_ye       = r_sel ? ~r_y : r_y;
  assign w_overflow = (r_x[7] == w_ye[7]) && (bus.RESULT_IN[7] != r_x[7]);
  assign bus.OVERFLOW = r_overflow;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= LOAD_X;
      r_ready    <= 1'b1;
      r_x        <= '0;
      r_y        <= '0;
      r_sel      <= 1'b0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_done     <= 1'b0;
      r_op_count <= '0;
`ifdef ADDER_SEQ_OVERFLOW_EN
      r_overflow <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        LOAD_X: begin
          if (w_xfer) begin
            r_x     <= bus.DATA_IN;
            r_sel   <= bus.OP_SEL;
            r_state <= LOAD_Y;
          end
        end
        LOAD_Y: begin
          if (w_xfer) begin
            r_y     <= bus.DATA_IN;
            r_state <= EXEC;
            r_ready <= 1'b0;
          end
        end
        EXEC: begin
          // Adder has settled for one full cycle; capture unmodified.
          r_result   <= bus.RESULT_IN;
          r_carry    <= bus.CARRY_IN;
          r_done     <= 1'b1;
          r_op_count <= r_op_count + 8'd1;
`ifdef ADDER_SEQ_OVERFLOW_EN
          r_overflow <= w_overflow;
`endif
          r_state    <= LOAD_X;
          r_ready    <= 1'b1;
        end
        default: begin
          r_state <= LOAD_X;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.READY    = r_ready;
  assign bus.X        = r_x;
  assign bus.Y        = r_y;
  assign bus.SEL      = r_sel;
  assign bus.RESULT   = r_result;
  assign bus.CARRY    = r_carry;
  assign bus.DONE     = r_done;
  assign bus.OP_COUNT = r_op_count;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
module tb_adder_operand_sequencer;

  logic CLK;
  logic RST;
  int   cyc;
  int   n_chk;
  int   n_fail;
  logic mon_en;

  adder_operand_sequencer_if bus ();

  adder_operand_sequencer dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // External 8-bit adder: subtraction is X + ~Y + 1.
  logic [8:0] adder_sum;
  assign adder_sum     = {1'b0, bus.X} + {1'b0, (bus.SEL ? ~bus.Y : bus.Y)} + {8'd0, bus.SEL};
  assign bus.RESULT_IN = adder_sum[7:0];
  assign bus.CARRY_IN  = adder_sum[8];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic [7:0] cnt;
    logic       ovf;
    int         dcyc;
  } exp_t;

  exp_t q[$];

  // Model state: operands last transferred and last completed result.
  logic [7:0] m_x, m_y, m_res, m_cnt;
  logic       m_sel, m_c;
`ifdef ADDER_SEQ_OVERFLOW_EN
  logic       m_ovf;
`endif
  int         exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    bus.DATA_VALID = 1'b0;
    bus.DATA_IN    = 8'($urandom);
    bus.OP_SEL     = 1'($urandom);
    repeat (n) @(negedge CLK);
  endtask

  // Presents a byte and waits for it to be taken; returns at the next negedge.
  task automatic xfer(input logic [7:0] d, input logic op, input logic is_y,
                      output int waits, output int tcyc);
    bus.DATA_IN    = d;
    bus.OP_SEL     = op;
    bus.DATA_VALID = 1'b1;
    waits = 0;
    while (bus.READY !== 1'b1 && waits < 20) begin
      @(negedge CLK);
      waits++;
    end
    if (waits >= 20) chk("ready_timeout", 32'd0, 32'd1);
    tcyc = cyc;
    @(posedge CLK);
    if (!is_y) begin
      m_x   = d;
      m_sel = op;
    end else begin
      m_y = d;
    end
    @(negedge CLK);
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic op,
                       input int gap, output int xwait);
    int   w, tc, sx, sy, sr;
    exp_t e;
    xfer(x, op, 1'b0, xwait, tc);
    if (gap > 0) idle(gap);
    // OP_SEL is deliberately inverted during the Y byte: it must be ignored.
    xfer(y, ~op, 1'b1, w, tc);
    if (!op) begin
      e.res = 8'((int'(x) + int'(y)) % 256);
      e.c   = (int'(x) + int'(y)) > 255;
    end else begin
      e.res = 8'((int'(x) - int'(y) + 256) % 256);
      e.c   = int'(x) >= int'(y);
    end
    sx = (x > 8'd127) ? int'(x) - 256 : int'(x);
    sy = (y > 8'd127) ? int'(y) - 256 : int'(y);
    sr = op ? sx - sy : sx + sy;
    e.ovf  = (sr > 127) || (sr < -128);
    exp_cnt++;
    e.cnt  = 8'(exp_cnt % 256);
    e.dcyc = tc + 2;
    q.push_back(e);
    chk("ready_in_exec", 32'(bus.READY), 32'd0);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (bus.DONE === 1'b1) begin
          if (q.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.dcyc));
            chk("result", 32'(bus.RESULT), 32'(e.res));
            chk("carry", 32'(bus.CARRY), 32'(e.c));
            chk("op_count", 32'(bus.OP_COUNT), 32'(e.cnt));
`ifdef ADDER_SEQ_OVERFLOW_EN
            chk("overflow", 32'(bus.OVERFLOW), 32'(e.ovf));
            m_ovf = e.ovf;
`endif
            m_res = e.res;
            m_c   = e.c;
            m_cnt = e.cnt;
          end
        end else if (q.size() > 0 && cyc >= q[0].dcyc) begin
          e = q.pop_front();
          chk("done_missing", 32'd0, 32'd1);
        end
        chk("x_hold", 32'(bus.X), 32'(m_x));
        chk("y_hold", 32'(bus.Y), 32'(m_y));
        chk("sel_hold", 32'(bus.SEL), 32'(m_sel));
        chk("result_hold", 32'(bus.RESULT), 32'(m_res));
        chk("carry_hold", 32'(bus.CARRY), 32'(m_c));
        chk("count_hold", 32'(bus.OP_COUNT), 32'(m_cnt));
`ifdef ADDER_SEQ_OVERFLOW_EN
        chk("overflow_hold", 32'(bus.OVERFLOW), 32'(m_ovf));
`endif
      end
    end
  end

  task automatic model_reset();
    m_x = '0; m_y = '0; m_sel = 1'b0;
    m_res = '0; m_c = 1'b0; m_cnt = '0;
`ifdef ADDER_SEQ_OVERFLOW_EN
    m_ovf = 1'b0;
`endif
    exp_cnt = 0;
  endtask

  typedef struct { logic [7:0] x; logic [7:0] y; logic op; } dir_t;
  dir_t dir[7];

  initial begin
    int xw, tc;
    n_chk = 0; n_fail = 0; mon_en = 1'b0;
    model_reset();
    dir[0] = '{8'h11, 8'h11, 1'b0};
    dir[1] = '{8'h11, 8'h11, 1'b1};
    dir[2] = '{8'hAA, 8'h55, 1'b0};
    dir[3] = '{8'hAA, 8'h55, 1'b1};
    dir[4] = '{8'hFF, 8'h01, 1'b0};
    dir[5] = '{8'h7F, 8'h01, 1'b0};
    dir[6] = '{8'hFF, 8'h01, 1'b0};

    RST = 1'b1;
    bus.DATA_VALID = 1'b0;
    bus.DATA_IN = '0;
    bus.OP_SEL = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("reset_ready", 32'(bus.READY), 32'd1);
    chk("reset_done", 32'(bus.DONE), 32'd0);
    chk("reset_count", 32'(bus.OP_COUNT), 32'd0);
    mon_en = 1'b1;
    @(negedge CLK);

    // Directed ops back-to-back with DATA_VALID never dropping.
    for (int i = 0; i < 7; i++) begin
      do_op(dir[i].x, dir[i].y, dir[i].op, 0, xw);
      if (i > 0) chk("b2b_x_wait", 32'(xw), 32'd1);
    end
    idle(3);

    // Reset after the X transfer, with a competing byte offered.
    xfer(8'h5A, 1'b1, 1'b0, xw, tc);
    bus.DATA_VALID = 1'b1;
    bus.DATA_IN    = 8'h3C;
    RST = 1'b1;
    @(posedge CLK);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    bus.DATA_VALID = 1'b0;
    chk("midrst_ready", 32'(bus.READY), 32'd1);
    chk("midrst_x", 32'(bus.X), 32'd0);
    chk("midrst_count", 32'(bus.OP_COUNT), 32'd0);
    idle(4);
    do_op(8'h11, 8'h11, 1'b0, 0, xw);
    idle(2);
    chk("midrst_next_count", 32'(bus.OP_COUNT), 32'd1);

    // Random ops: enough to wrap OP_COUNT past 0xFF.
    for (int i = 0; i < 270; i++) begin
      idle(int'($urandom_range(0, 2)));
      do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), xw);
    end
    idle(5);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
